spell_mem_io: RTL
=================

# spell_mem_io

Memory and I/O back-end of the spell core; it sits directly downstream of the core's memory port.
- Serves every code-fetch, data-fetch and store request through a single select/data_ready handshake.
- Code space: external single-port SRAM macro (OpenRAM-style, active-low controls).
- Data space: internal flip-flop array.
- I/O space: a small GPIO register bank.

## Interface
Parameters:
- DATA_WORDS, 32, depth of internal data memory (power of two, ≤256)
- CODE_LATENCY, 1, SRAM read latency in cycles (1..3)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- select  in  1  request valid; held high by core until data_ready seen
- addr  in  8  byte address
- data_in  in  8  write data
- memory_type  in  2  space select (see package)
- write  in  1  1 = store, 0 = load
- data_out  out  8  load result, valid while data_ready=1
- data_ready  out  1  one-cycle completion pulse
- sram_csb  out  1  SRAM chip select, active-low
- sram_web  out  1  SRAM write enable, active-low
- sram_addr  out  8  SRAM address
- sram_din  out  8  SRAM write data
- sram_dout  in  8  SRAM read data
- gpio_in  in  8  asynchronous pins
- gpio_out  out  8  output register
- gpio_oe  out  8  output-enable register

## Operation
- Request is accepted only in IDLE with select=1. On acceptance, addr, data_in, memory_type and write are latched. Inputs are ignored until the next IDLE.
- FSM states and transitions:
  - IDLE→ACCESS on select.
  - ACCESS→DONE for data, I/O and None types.
  - ACCESS→WAIT for Code type.
  - WAIT→DONE after CODE_LATENCY cycles.
  - DONE→IDLE unconditionally.
- data_ready=1 only in DONE.
- Data type:
  - Index = addr mod DATA_WORDS (upper bits dropped, wrap-around).
  - Store writes mem[index]; data_out = 0.
  - Load: data_out = mem[index].
- Code type:
  - In ACCESS: sram_csb=0, sram_web=!write, sram_addr/sram_din driven from latched values.
  - sram_csb=1 in all other states.
  - Load captures sram_dout at the end of the last WAIT cycle. Store: data_out = 0.
- I/O type:
  - addr 0: gpio_out, read/write.
  - addr 1: gpio_oe, read/write.
  - addr 2: synchronized gpio_in, read-only; writes ignored.
  - Any other addr reads 0; writes to it are ignored.
- None type: no side effect; data_out = 0; completes with data/I/O timing.
- gpio_in passes through a 2-flop synchronizer before it is readable.

## Timing
- Let select be first high in IDLE in cycle N.
  - Data/I/O/None: ACCESS in N+1, data_ready in N+2; the write takes effect at the end of N+1.
  - Code: sram_csb low in N+1 only, WAIT for N+2..N+1+CODE_LATENCY, data_ready in N+2+CODE_LATENCY.
- DONE is always followed by at least one IDLE cycle. The core drops select on the edge where it sees data_ready, so back-to-back requests are spaced ≥1 idle cycle apart and no request is double-issued.
- If select is high in IDLE immediately after DONE, it is a new request and is accepted.
- data_out holds its value until the next DONE.
- gpio_in→readable latency: 2 cycles. gpio_out/gpio_oe update on the edge ending ACCESS.
- Reset values (any cycle, including mid-transaction, where it aborts without ready):
  - FSM IDLE; data_ready 0; data_out 0.
  - sram_csb 1, sram_web 1, sram_addr 0, sram_din 0.
  - gpio_out 0, gpio_oe 0; synchronizer 0.
  - All data memory 0.
  - A code store aborted by reset may or may not have reached the SRAM.

## Structure
- Shared package spell_pkg holds the 2-bit memory type constants, also used by the core's store logic:
  - MemoryTypeData=2'b00
  - MemoryTypeCode=2'b01
  - MemoryTypeIO=2'b10
  - MemoryTypeNone=2'b11
- The package also holds the I/O address constants (IoGpioOut=0, IoGpioOe=1, IoGpioIn=2).
- One sub-module: spell_gpio_sync, the 8-bit 2-flop synchronizer.
- FSM, data array and SRAM sequencing stay in spell_mem_io.

## Test plan
- Data store then load: store addr 0x05 data 0xA5, then load addr 0x25 (wraps to 5) → data_ready in N+2 each time; load returns 0xA5.
- Code load, CODE_LATENCY=1, SRAM model returns 0x3F at addr 0x10 → sram_csb low only in N+1 with sram_addr=0x10 and sram_web=1; data_ready in N+3; data_out=0x3F.
- I/O: store addr 0 data 0x81 and addr 1 data 0xFF → gpio_out=0x81 and gpio_oe=0xFF. Load addr 2 ≥2 cycles after gpio_in=0x5A → 0x5A. Load addr 7 → 0x00.
- Handshake: hold select high continuously across 3 data loads → exactly 3 data_ready pulses, each separated by ≥1 IDLE cycle.
- None type store of 0x77 → data_ready at N+2; data_out=0; no data, I/O or SRAM change (sram_csb stays 1).
- Reset asserted during a code WAIT → no data_ready. After release, all outputs are at reset values and a new data load of addr 0 returns 0x00.

Source files
------------

// File: rtl/spell_pkg.sv
// Shared definitions for the spell core memory back-end.
// Memory-space codes are also used by the core's store logic.
// I/O register addresses and the back-end FSM state type live here too.
package spell_pkg;

  // Memory space select codes
  localparam logic [1:0] MemoryTypeData = 2'b00;
  localparam logic [1:0] MemoryTypeCode = 2'b01;
  localparam logic [1:0] MemoryTypeIO   = 2'b10;
  localparam logic [1:0] MemoryTypeNone = 2'b11;

  // GPIO register bank addresses within the I/O space
  localparam logic [7:0] IoGpioOut = 8'd0;
  localparam logic [7:0] IoGpioOe  = 8'd1;
  localparam logic [7:0] IoGpioIn  = 8'd2;

  // Back-end request sequencer states
  typedef enum logic [1:0] {
    StateIdle   = 2'd0,
    StateAccess = 2'd1,
    StateWait   = 2'd2,
    StateDone   = 2'd3
  } mem_io_state_t;

  // Code requests are the only ones that go off-chip and need a wait phase
  function automatic logic is_code_space(input logic [1:0] memory_type);
    return memory_type == MemoryTypeCode;
  endfunction

endpackage

// File: rtl/spell_gpio_sync.sv
// Purpose: two-flop synchronizer bringing asynchronous GPIO pins into the clock domain.
// Latency: 2 cycles from a stable pin level to sync_out.
// Backpressure: none; free-running every cycle.
module spell_gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clock) begin
    if (reset) begin
      meta     <= '0;
      sync_out <= '0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/spell_mem_io.sv
// Purpose: memory/I-O back-end serving code (external SRAM), data (flop array) and GPIO requests.
// Latency: data_ready 2 cycles after acceptance for data/I-O/none, 2+CODE_LATENCY for code.
// Backpressure: one request in flight; select is only sampled in IDLE, inputs ignored until IDLE again.
module spell_mem_io
  import spell_pkg::*;
#(
  parameter int DATA_WORDS   = 32,
  parameter int CODE_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       select,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic [1:0] memory_type,
  input  logic       write,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       sram_csb,
  output logic       sram_web,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_din,
  input  logic [7:0] sram_dout,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic [7:0] gpio_oe
);

  localparam int IDX_W = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  // Wait counter starts at CODE_LATENCY-1 so the last WAIT cycle is the one with count 0
  localparam logic [1:0] WaitInit = 2'(CODE_LATENCY - 1);

  if (CODE_LATENCY < 1 || CODE_LATENCY > 3) begin : g_bad_latency
    $error("spell_mem_io: CODE_LATENCY must be 1..3");
  end
  if (DATA_WORDS < 2 || DATA_WORDS > 256 || (DATA_WORDS & (DATA_WORDS - 1)) != 0) begin : g_bad_depth
    $error("spell_mem_io: DATA_WORDS must be a power of two in 2..256");
  end

  mem_io_state_t    state;
  logic [7:0]       lat_addr;
  logic [7:0]       lat_din;
  logic [1:0]       lat_type;
  logic             lat_write;
  logic [1:0]       wait_cnt;

  logic [7:0]       data_mem [DATA_WORDS];
  logic [IDX_W-1:0] data_idx;
  logic [7:0]       gpio_in_sync;
  logic [7:0]       access_rdata;
  logic             data_we;
  logic             io_we;

  spell_gpio_sync #(
    .WIDTH(8)
  ) u_gpio_sync (
    .clock   (clock),
    .reset   (reset),
    .async_in(gpio_in),
    .sync_out(gpio_in_sync)
  );

  // Data index keeps only the low address bits, so addresses wrap around the array
  assign data_idx = lat_addr[IDX_W-1:0];
  // Stores commit on the edge that ends ACCESS
  assign data_we  = (state == StateAccess) && (lat_type == MemoryTypeData) && lat_write;
  assign io_we    = (state == StateAccess) && (lat_type == MemoryTypeIO) && lat_write;

  // Read value for on-chip spaces; stores and the None space return zero
  always_comb begin
    access_rdata = '0;
    if (!lat_write) begin
      case (lat_type)
        MemoryTypeData: access_rdata = data_mem[data_idx];
        MemoryTypeIO: begin
          case (lat_addr)
            IoGpioOut: access_rdata = gpio_out;
            IoGpioOe:  access_rdata = gpio_oe;
            IoGpioIn:  access_rdata = gpio_in_sync;
            default:   access_rdata = '0;
          endcase
        end
        default: access_rdata = '0;
      endcase
    end
  end

  // Request sequencer: latches the request, drives the SRAM strobe and registers the result
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= StateIdle;
      lat_addr   <= '0;
      lat_din    <= '0;
      lat_type   <= MemoryTypeNone;
      lat_write  <= 1'b0;
      wait_cnt   <= '0;
      data_out   <= '0;
      data_ready <= 1'b0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_addr  <= '0;
      sram_din   <= '0;
    end else begin
      data_ready <= 1'b0;
      case (state)
        StateIdle: begin
          if (select) begin
            lat_addr  <= addr;
            lat_din   <= data_in;
            lat_type  <= memory_type;
            lat_write <= write;
            state     <= StateAccess;
            // SRAM control is registered so the strobe lines up exactly with ACCESS
            if (is_code_space(memory_type)) begin
              sram_csb  <= 1'b0;
              sram_web  <= ~write;
              sram_addr <= addr;
              sram_din  <= data_in;
            end
          end
        end
        StateAccess: begin
          sram_csb <= 1'b1;
          sram_web <= 1'b1;
          if (is_code_space(lat_type)) begin
            wait_cnt <= WaitInit;
            state    <= StateWait;
          end else begin
            data_out   <= access_rdata;
            data_ready <= 1'b1;
            state      <= StateDone;
          end
        end
        StateWait: begin
          if (wait_cnt == 2'd0) begin
            data_out   <= lat_write ? 8'h00 : sram_dout;
            data_ready <= 1'b1;
            state      <= StateDone;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        StateDone: begin
          state <= StateIdle;
        end
        default: begin
          state <= StateIdle;
        end
      endcase
    end
  end

  // Data flop array; reset clears every word
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DATA_WORDS; i++) begin
        data_mem[i] <= '0;
      end
    end else if (data_we) begin
      data_mem[data_idx] <= lat_din;
    end
  end

  // GPIO output and output-enable registers; the input register address is read-only
  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
    end else if (io_we) begin
      case (lat_addr)
        IoGpioOut: gpio_out <= lat_din;
        IoGpioOe:  gpio_oe  <= lat_din;
        default:   ;
      endcase
    end
  end

endmodule
